// File: rtl/text_term_writer.sv
// text_term_writer
//   Character-stream writer for a COLS x ROWS text memory. Accepts one byte
//   per in_valid/in_ready handshake, writes printable codes at a hardware
//   cursor, handles CR / LF / BS / FF, and scrolls the screen up one row
//   through the memory's synchronous read port when the cursor runs off the
//   bottom row.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   in_data/in_valid    incoming character byte and its valid flag
//   in_ready            high while idle; a byte is taken on in_valid & in_ready
//   mem_waddr/wdata/we  text memory write port, one write per asserted cycle
//   mem_raddr/rdata     text memory read port, rdata valid one cycle later
//   cursor_addr         cursor_row*COLS + cursor_col
//   busy                high whenever the writer is not idle
module text_term_writer #(
  parameter int COLS   = 40,
  parameter int ROWS   = 25,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [7:0]        mem_rdata,
  output logic [ADDR_W-1:0] cursor_addr,
  output logic              busy
);

  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(COLS * ROWS - 1);
  localparam logic [ADDR_W-1:0] LROW_A   = ADDR_W'((ROWS - 1) * COLS);
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [7:0]        SPACE    = 8'h20;

  typedef enum logic [2:0] {
    IDLE,
    PUT,
    SCROLL_RD,
    SCROLL_WR,
    SCROLL_CLR,
    CLEAR
  } state_e;

  state_e              state_q, state_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ADDR_W-1:0]   src_q, src_d;      // scroll source / clear address
  logic                adv_q, adv_d;      // PUT advances cursor (printable only)
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [7:0]          wdata_q, wdata_d;
  logic [ADDR_W-1:0]   raddr_q, raddr_d;

  assign cursor_addr = ADDR_W'(row_q) * COLS_A + ADDR_W'(col_q);
  assign in_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign mem_we      = we_q;
  assign mem_waddr   = waddr_q;
  assign mem_raddr   = raddr_q;
  // The RAM returns the scrolled character during SCROLL_WR itself, so the
  // write data is taken straight from the read port in that state; every
  // other write uses the registered data.
  assign mem_wdata   = (state_q == SCROLL_WR) ? mem_rdata : wdata_q;

  // The mem_* registers are loaded with the values belonging to the state
  // being entered, so each write appears in the same cycle as its state.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    src_d   = src_q;
    adv_d   = adv_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    raddr_d = raddr_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_data >= 8'h20 && in_data <= 8'h7E) begin
            state_d = PUT;
            adv_d   = 1'b1;
            we_d    = 1'b1;
            waddr_d = cursor_addr;
            wdata_d = in_data;
          end else begin
            unique case (in_data)
              8'h0D: col_d = '0;
              8'h0A: begin
                col_d = '0;
                if (row_q != ROW_LAST) begin
                  row_d = row_q + ROW_W'(1);
                end else begin
                  state_d = SCROLL_RD;
                  src_d   = COLS_A;
                  raddr_d = COLS_A;
                end
              end
              8'h08: begin
                // Step back one cell (wrapping to the previous row) and blank it.
                if (cursor_addr != '0) begin
                  if (col_q != '0) begin
                    col_d = col_q - COL_W'(1);
                  end else begin
                    row_d = row_q - ROW_W'(1);
                    col_d = COL_LAST;
                  end
                  state_d = PUT;
                  adv_d   = 1'b0;
                  we_d    = 1'b1;
                  waddr_d = cursor_addr - ADDR_W'(1);
                  wdata_d = SPACE;
                end
              end
              8'h0C: begin
                row_d   = '0;
                col_d   = '0;
                state_d = CLEAR;
                src_d   = '0;
                we_d    = 1'b1;
                waddr_d = '0;
                wdata_d = SPACE;
              end
              default: ;
            endcase
          end
        end
      end

      PUT: begin
        state_d = IDLE;
        if (adv_q) begin
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              state_d = SCROLL_RD;
              src_d   = COLS_A;
              raddr_d = COLS_A;
            end else begin
              row_d = row_q + ROW_W'(1);
            end
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end

      SCROLL_RD: begin
        state_d = SCROLL_WR;
        we_d    = 1'b1;
        waddr_d = src_q - COLS_A;
      end

      SCROLL_WR: begin
        if (src_q == LAST_A) begin
          state_d = SCROLL_CLR;
          src_d   = LROW_A;
          we_d    = 1'b1;
          waddr_d = LROW_A;
          wdata_d = SPACE;
        end else begin
          state_d = SCROLL_RD;
          src_d   = src_q + ADDR_W'(1);
          raddr_d = src_q + ADDR_W'(1);
        end
      end

      SCROLL_CLR, CLEAR: begin
        if (src_q == LAST_A) begin
          state_d = IDLE;
        end else begin
          src_d   = src_q + ADDR_W'(1);
          we_d    = 1'b1;
          waddr_d = src_q + ADDR_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      src_q   <= '0;
      adv_q   <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      raddr_q <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      src_q   <= src_d;
      adv_q   <= adv_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      raddr_q <= raddr_d;
    end
  end

endmodule

// File: tb/tb_text_term_writer.sv
// tb_text_term_writer
//   Self-checking bench for text_term_writer. Holds a synchronous RAM model
//   on the memory ports and a screen-level reference model (character array
//   plus cursor row/col) that applies the terminal rules to each byte.
module tb_text_term_writer;

  localparam int COLS   = 40;
  localparam int ROWS   = 25;
  localparam int ADDR_W = 10;
  localparam int CELLS  = COLS * ROWS;
  localparam int RING   = 4096;
  localparam int SCROLL_CYCLES = 2 * (ROWS - 1) * COLS + COLS;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_waddr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_raddr;
  logic [7:0]        mem_rdata = 8'h00;
  logic [ADDR_W-1:0] cursor_addr;
  logic              busy;

  always #5 clk = ~clk;

  text_term_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_raddr  (mem_raddr),
    .mem_rdata  (mem_rdata),
    .cursor_addr(cursor_addr),
    .busy       (busy)
  );

  // Synchronous RAM; fill_req preloads cell i with i[7:0].
  logic [7:0] ram [0:(1<<ADDR_W)-1];
  logic       fill_req = 1'b0;

  always @(posedge clk) begin
    if (fill_req) begin
      for (int i = 0; i < (1 << ADDR_W); i++) ram[i] <= 8'(i);
    end else if (mem_we) begin
      ram[mem_waddr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_raddr];
  end

  // Write log, sampled on the falling edge.
  int         ncyc = 0;
  int         wr_n = 0;
  int         wr_addr [0:RING-1];
  logic [7:0] wr_data [0:RING-1];
  int         wr_cyc  [0:RING-1];

  always @(negedge clk) begin
    ncyc <= ncyc + 1;
    if (mem_we) begin
      wr_addr[wr_n % RING] <= int'(mem_waddr);
      wr_data[wr_n % RING] <= mem_wdata;
      wr_cyc[wr_n % RING]  <= ncyc + 1;
      wr_n <= wr_n + 1;
    end
  end

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: screen contents and cursor.
  logic [7:0] m_scr [0:CELLS-1];
  int         m_row = 0;
  int         m_col = 0;

  task automatic scroll_model();
    for (int k = 0; k < CELLS - COLS; k++) m_scr[k] = m_scr[k + COLS];
    for (int k = CELLS - COLS; k < CELLS; k++) m_scr[k] = 8'h20;
  endtask

  task automatic model_step(input logic [7:0] b, output int e_busy, output int e_nwr,
                            output int e_off, output int e_addr, output logic [7:0] e_data);
    int pos;
    e_busy = 0; e_nwr = 0; e_off = 0; e_addr = 0; e_data = 8'h00;
    if (b >= 8'h20 && b <= 8'h7E) begin
      e_addr = m_row * COLS + m_col;
      e_data = b;
      m_scr[e_addr] = b;
      e_busy = 1; e_nwr = 1; e_off = 1;
      m_col++;
      if (m_col == COLS) begin
        m_col = 0;
        m_row++;
        if (m_row == ROWS) begin
          m_row = ROWS - 1;
          scroll_model();
          e_busy += SCROLL_CYCLES;
          e_nwr  += CELLS;
        end
      end
    end else begin
      case (b)
        8'h0D: m_col = 0;
        8'h0A: begin
          m_col = 0;
          if (m_row < ROWS - 1) begin
            m_row++;
          end else begin
            e_addr = 0;
            e_data = m_scr[COLS];
            scroll_model();
            e_busy = SCROLL_CYCLES; e_nwr = CELLS; e_off = 2;
          end
        end
        8'h08: begin
          pos = m_row * COLS + m_col;
          if (pos > 0) begin
            pos--;
            m_row = pos / COLS;
            m_col = pos % COLS;
            m_scr[pos] = 8'h20;
            e_addr = pos; e_data = 8'h20;
            e_busy = 1; e_nwr = 1; e_off = 1;
          end
        end
        8'h0C: begin
          for (int k = 0; k < CELLS; k++) m_scr[k] = 8'h20;
          m_row = 0; m_col = 0;
          e_addr = 0; e_data = 8'h20;
          e_busy = CELLS; e_nwr = CELLS; e_off = 1;
        end
        default: ;
      endcase
    end
  endtask

  task automatic send(input logic [7:0] b);
    int e_busy, e_nwr, e_off, e_addr, t, acc, base, cyc, idx;
    logic [7:0] e_data;
    t = 0;
    while (in_ready !== 1'b1 && t < 4000) begin
      t++;
      @(negedge clk);
    end
    check("ready_before_send", {31'd0, in_ready}, 32'd1);
    model_step(b, e_busy, e_nwr, e_off, e_addr, e_data);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    acc  = ncyc;
    base = wr_n;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    cyc = 0;
    while (busy === 1'b1 && cyc < 3000) begin
      cyc++;
      @(negedge clk);
    end
    #1;
    check($sformatf("busy_cycles[%02h]", b), cyc, e_busy);
    check($sformatf("write_count[%02h]", b), wr_n - base, e_nwr);
    if (e_nwr > 0 && wr_n > base) begin
      idx = base % RING;
      check($sformatf("first_waddr[%02h]", b), wr_addr[idx], e_addr);
      check($sformatf("first_wdata[%02h]", b), {24'd0, wr_data[idx]}, {24'd0, e_data});
      check($sformatf("first_wr_latency[%02h]", b), wr_cyc[idx] - acc, e_off);
    end
    check($sformatf("cursor[%02h]", b), {22'd0, cursor_addr}, m_row * COLS + m_col);
    check("ready_after_send", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic compare_mem(input string tag);
    for (int i = 0; i < CELLS; i++)
      check($sformatf("%s_mem[%0d]", tag, i), {24'd0, ram[i]}, {24'd0, m_scr[i]});
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, base;
    logic [7:0] old_scr [0:CELLS-1];
    logic [7:0] b;

    for (int k = 0; k < CELLS; k++) m_scr[k] = 8'h00;

    // Reset values.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mem_we",    {31'd0, mem_we}, 32'd0);
    check("rst_mem_waddr", {22'd0, mem_waddr}, 32'd0);
    check("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    check("rst_mem_raddr", {22'd0, mem_raddr}, 32'd0);
    check("rst_busy",      {31'd0, busy}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready}, 32'd1);
    check("rst_cursor",    {22'd0, cursor_addr}, 32'd0);

    // BS at origin, then a full row of printables, then BS at (1,0).
    send(8'h08);
    send(8'h41);
    for (int i = 1; i < COLS; i++) send(8'($urandom_range(32, 126)));
    check("row_wrap_cursor", {22'd0, cursor_addr}, COLS);
    send(8'h08);

    // Form feed clears everything.
    send(8'h0C);
    compare_mem("ff");

    // Preload i[7:0], walk to the bottom row, then scroll with LF.
    @(negedge clk);
    fill_req = 1'b1;
    @(negedge clk);
    fill_req = 1'b0;
    for (int k = 0; k < CELLS; k++) m_scr[k] = 8'(k);
    for (int i = 0; i < ROWS - 1; i++) send(8'h0A);
    send(8'h0A);
    compare_mem("scroll");
    check("scroll_cursor", {22'd0, cursor_addr}, (ROWS - 1) * COLS);

    // Reset 500 cycles into a scroll.
    for (int k = 0; k < CELLS; k++) old_scr[k] = m_scr[k];
    in_data  = 8'h0A;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    base = wr_n;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (499) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_mem_we", {31'd0, mem_we}, 32'd0);
    check("midrst_busy",   {31'd0, busy}, 32'd0);
    check("midrst_cursor", {22'd0, cursor_addr}, 32'd0);
    check("midrst_ready",  {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    #1;
    check("midrst_write_count", wr_n - base, 250);
    for (int k = 0; k < 250; k++) begin
      check("midrst_waddr", wr_addr[(base + k) % RING], k);
      check("midrst_wdata", {24'd0, wr_data[(base + k) % RING]}, {24'd0, old_scr[k + COLS]});
      m_scr[k] = old_scr[k + COLS];
    end
    m_row = 0;
    m_col = 0;
    base = wr_n;
    repeat (5) @(negedge clk);
    #1;
    check("midrst_no_more_writes", wr_n - base, 0);
    send(8'h41);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      b = 8'($urandom_range(32, 126));
      else if (r < 78) b = 8'h0A;
      else if (r < 84) b = 8'h0D;
      else if (r < 92) b = 8'h08;
      else if (r < 94) b = 8'h0C;
      else             b = 8'($urandom_range(0, 255));
      send(b);
    end
    compare_mem("random");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/text_term_writer.md
Name: text_term_writer

Overview:
Character-stream writer for the 40x25 VGA text memory, on the opposite port from the scan-out text generator. Accepts one byte per valid/ready handshake and writes printable codes at a hardware cursor. Handles control codes: CR, LF, BS and form-feed clear. Scrolls the screen up one row when the cursor passes the last row, using the memory's read port.

Parameters:
COLS, 40, characters per row
ROWS, 25, rows on screen
ADDR_W, 10, text memory address width (COLS*ROWS must be <= 2^ADDR_W)

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  synchronous reset, active-low
in_data  input  8  character code from CPU/UART side
in_valid  input  1  in_data is valid
in_ready  output  1  block can accept a byte this cycle
mem_waddr  output  ADDR_W  text memory write address
mem_wdata  output  8  text memory write data
mem_we  output  1  text memory write enable, one cycle per write
mem_raddr  output  ADDR_W  text memory read address
mem_rdata  input  8  read data, valid one cycle after mem_raddr is presented (synchronous RAM)
cursor_addr  output  ADDR_W  cursor_row*COLS + cursor_col
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset: when rst_n=0 at a clock edge, the block enters IDLE on that edge, from any state (including mid-scroll or mid-clear).
  - Reset values: cursor_row=0, cursor_col=0, mem_we=0, mem_waddr=0, mem_wdata=0, mem_raddr=0, busy=0, in_ready=1 from the first cycle after reset.
  - Memory contents are not cleared by reset.
- Handshake:
  - in_ready = (state==IDLE).
  - A byte is accepted on a cycle with in_valid & in_ready.
  - in_data is sampled only on that cycle.
  - No byte is accepted while busy.
- States: IDLE, PUT, SCROLL_RD, SCROLL_WR, SCROLL_CLR, CLEAR.
- Decode on accept:
  - 0x20..0x7E: go to PUT.
  - 0x0D (CR): cursor_col=0; stay IDLE.
  - 0x0A (LF): cursor_col=0.
    - If cursor_row<ROWS-1: cursor_row+1, stay IDLE.
    - Else: go SCROLL_RD.
  - 0x08 (BS):
    - If col>0: col-1.
    - Else if row>0: row-1 and col=COLS-1.
    - At (0,0): no-op, stay IDLE.
    - Otherwise go PUT with a latched char of 0x20, and without the cursor advance.
  - 0x0C (FF): go CLEAR.
  - Any other code: ignored; accepted, no state change.
- PUT (1 cycle):
  - Drives mem_we=1, mem_waddr=cursor_addr (pre-advance), mem_wdata=latched char.
  - Advance (printable only): col+1. If col==COLS-1, then col=0 and row+1.
  - If row was ROWS-1 and col wrapped: row stays ROWS-1, col=0, next state SCROLL_RD. Otherwise next state IDLE.
  - Printable throughput: 1 byte per 2 cycles.
- Scroll:
  - Source counter src runs from COLS to COLS*ROWS-1.
  - SCROLL_RD: mem_raddr=src, mem_we=0.
  - SCROLL_WR: mem_we=1, mem_waddr=src-COLS, mem_wdata=mem_rdata; then src+1.
  - After src=COLS*ROWS-1 is written, go SCROLL_CLR.
  - SCROLL_CLR: writes 0x20 to addresses (ROWS-1)*COLS .. COLS*ROWS-1, one per cycle, then IDLE.
  - Total: 2*(ROWS-1)*COLS + COLS cycles = 1960 at defaults.
  - Cursor stays at (ROWS-1, 0).
- CLEAR:
  - Writes 0x20 to addresses 0..COLS*ROWS-1, one per cycle (1000 cycles).
  - Cursor is set to (0,0) on entry; then IDLE.
- Widths: all address arithmetic is ADDR_W bits unsigned. mem_* outputs are registered.
- Read/write overlap: mem_we is never asserted in the same cycle as a needed read. A read address never equals a pending write address during a scroll (src-COLS < src).
- cursor_addr is combinational from the cursor registers and always < COLS*ROWS.

Test Plan:
- Reset, then send 0x41 -> one cycle later mem_we=1, mem_waddr=0, mem_wdata=0x41; then cursor_addr=1, in_ready=1.
- Send 40 printable bytes from reset -> last write at addr 39; cursor_addr=40 (row1, col0); no scroll; busy never exceeds 1 cycle per byte.
- Fill memory so cell i holds i[7:0], cursor at row 24, send 0x0A:
  - busy for 1960 cycles.
  - Afterwards cell j == (j+40)[7:0] for j<960, and cells 960..999 == 0x20.
  - cursor_addr=960.
- Send BS at (0,0) -> no write, cursor stays 0. BS at (1,0) -> write 0x20 at addr 39, cursor_addr=39.
- Send 0x0C -> 1000 consecutive writes of 0x20 (addr 0..999); cursor_addr=0; in_ready low throughout.
- Assert rst_n=0 mid-scroll (cycle 500) -> next cycle mem_we=0, busy=0, cursor_addr=0; no further writes; a new byte is accepted normally.
